// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one RV32I memory request at a time against a word-wide memory,
// with sub-word loads extracted/extended and sub-word stores done as read-modify-write.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        accept;
    logic        req_misaligned;
    logic        req_illegal;
    logic        req_oor;
    logic        req_err;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign accept = req_valid & req_ready;

    always_comb begin
        req_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                       | ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        if (req_we)
            req_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            req_illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        req_oor = (req_addr >> ADDR_BITS) != '0;
        req_err = req_misaligned | req_illegal | req_oor;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_we && req_funct3 == 3'b010)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) & ~rst;
        MemRead   = (state_q == RD);
        MemWrite  = (state_q == WR);
        rsp_valid = (state_q == RESP);
        rsp_error = (state_q == RESP) & err_q;
        rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_val : '0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
    end

    // Merge is computed from live mem_rdata so the write word is ready on entry to WR.
    always_comb begin
        merged = mem_rdata;
        if (f3_q[1:0] == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_comb begin
        sel_byte = word_q[{lane_q, 3'b000} +: 8];
        sel_half = word_q[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {24'h000000, sel_byte};
            3'b101:  load_val = {16'h0000, sel_half};
            default: load_val = word_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata[15:0];
                err_q   <= req_err;
                if (!req_err)
                    mem_addr_q <= {req_addr[31:2], 2'b00};
                if (!req_err && req_we && req_funct3 == 3'b010)
                    mem_wdata_q <= req_wdata;
            end
            if (state_q == RD) begin
                word_q <= mem_rdata;
                if (we_q)
                    mem_wdata_q <= merged;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word memory model and an expected-response queue.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (MemWrite) mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rds;
        int          wrs;
        logic [31:0] wdata;
        logic [31:0] maddr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int total_wr = 0;
    logic [31:0] last_maddr = '0;
    logic [31:0] last_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: sample on the falling edge, pop the scoreboard on each response.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            chk("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
            if (MemRead) begin
                rd_cnt++;
                last_maddr = mem_addr;
            end
            if (MemWrite) begin
                wr_cnt++;
                total_wr++;
                last_maddr = mem_addr;
                last_wdata = mem_wdata;
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                    chk({e.tag, "_error"}, {31'b0, rsp_error}, {31'b0, e.err});
                    chk({e.tag, "_latency"}, cyc - acc_cyc, e.lat);
                    chk({e.tag, "_reads"}, rd_cnt, e.rds);
                    chk({e.tag, "_writes"}, wr_cnt, e.wrs);
                    if (e.rds + e.wrs > 0)
                        chk({e.tag, "_maddr"}, last_maddr, e.maddr);
                    if (e.wrs > 0)
                        chk({e.tag, "_wdata"}, last_wdata, e.wdata);
                end
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                rd_cnt  = 0;
                wr_cnt  = 0;
            end
        end
    end

    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erdata, input logic eerr, input int elat,
                         input int erds, input int ewrs, input logic [31:0] ewdata);
        exp_t e;
        logic acc;
        e.tag = tag; e.rdata = erdata; e.err = eerr; e.lat = elat;
        e.rds = erds; e.wrs = ewrs; e.wdata = ewdata; e.maddr = {addr[31:2], 2'b00};
        q.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        acc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, {31'b0, acc}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        req_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", q.size(), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
    endtask

    int wr_before;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[16] = 32'h8899AABB;
        mem[17] = 32'h01020304;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_ctrl", {28'b0, rsp_valid, rsp_error, MemRead, MemWrite}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        issue("lb41",  1'b0, 3'b000, 32'h41, '0, 32'hFFFFFFAA, 1'b0, 2, 1, 0, '0); drain();
        issue("lh42",  1'b0, 3'b001, 32'h42, '0, 32'hFFFF8899, 1'b0, 2, 1, 0, '0); drain();
        issue("lhu42", 1'b0, 3'b101, 32'h42, '0, 32'h00008899, 1'b0, 2, 1, 0, '0); drain();
        issue("lbu40", 1'b0, 3'b100, 32'h40, '0, 32'h000000BB, 1'b0, 2, 1, 0, '0); drain();
        issue("lw40",  1'b0, 3'b010, 32'h40, '0, 32'h8899AABB, 1'b0, 2, 1, 0, '0); drain();

        issue("sb43",  1'b1, 3'b000, 32'h43, 32'h123456CD, '0, 1'b0, 3, 1, 1, 32'hCD99AABB); drain();
        issue("lw40b", 1'b0, 3'b010, 32'h40, '0, 32'hCD99AABB, 1'b0, 2, 1, 0, '0); drain();
        issue("sh40",  1'b1, 3'b001, 32'h40, 32'h00001234, '0, 1'b0, 3, 1, 1, 32'hCD991234); drain();
        issue("lw40c", 1'b0, 3'b010, 32'h40, '0, 32'hCD991234, 1'b0, 2, 1, 0, '0); drain();

        issue("sw46_mis",  1'b1, 3'b010, 32'h46,  32'hFFFFFFFF, '0, 1'b1, 1, 0, 0, '0); drain();
        issue("lh41_mis",  1'b0, 3'b001, 32'h41,  '0, '0, 1'b1, 1, 0, 0, '0); drain();
        issue("ld011_ill", 1'b0, 3'b011, 32'h40,  '0, '0, 1'b1, 1, 0, 0, '0); drain();
        issue("st100_ill", 1'b1, 3'b100, 32'h40,  32'h55, '0, 1'b1, 1, 0, 0, '0); drain();
        issue("lw400_oor", 1'b0, 3'b010, 32'h400, '0, '0, 1'b1, 1, 0, 0, '0); drain();
        issue("lw3fc",     1'b0, 3'b010, 32'h3FC, '0, 32'h0, 1'b0, 2, 1, 0, '0); drain();
        chk("mem40_after_errors", mem[16], 32'hCD991234);

        // req_valid stays high across both requests
        issue("b2b_lw40", 1'b0, 3'b010, 32'h40, '0, 32'hCD991234, 1'b0, 2, 1, 0, '0);
        issue("b2b_sw44", 1'b1, 3'b010, 32'h44, 32'hDEADBEEF, '0, 1'b0, 2, 0, 1, 32'hDEADBEEF);
        drain();
        chk("mem44_after_sw", mem[17], 32'hDEADBEEF);

        wr_before = total_wr;
        issue("sh44_abort", 1'b1, 3'b001, 32'h44, 32'h0000AAAA, '0, 1'b0, 3, 1, 1, '0);
        req_valid = 1'b0;
        chk("abort_in_rd", {31'b0, MemRead}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {30'b0, MemRead, MemWrite}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        #1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_ctrl", {28'b0, rsp_valid, rsp_error, MemRead, MemWrite}, 32'd0);
        chk("post_rst_rdata", rsp_rdata, 32'd0);
        chk("post_rst_maddr", mem_addr, 32'd0);
        chk("post_rst_wdata", mem_wdata, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_write", total_wr - wr_before, 32'd0);
        chk("mem44_unchanged", mem[17], 32'hDEADBEEF);

        issue("lhu46", 1'b0, 3'b101, 32'h46, '0, 32'h0000DEAD, 1'b0, 2, 1, 0, '0); drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the core's execute stage and the word-wide `data_mem` port. It accepts one RV32I memory request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives `MemRead`, `MemWrite`, `mem_addr` and `mem_wdata`. Sub-word loads are extracted and extended. Sub-word stores are done as a read-modify-write, because memory writes whole words only. Misaligned, illegal or out-of-range requests return an error and never touch memory.

## Interface
- `ADDR_BITS`, default 10: number of byte-address bits backed by memory. Any address with a 1 in bits [31:ADDR_BITS] is out of range.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load/store.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  single-cycle completion pulse.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_error`  out  1  valid with `rsp_valid`: misaligned, illegal funct3 or out of range.
- `MemRead`  out  1  memory read enable.
- `MemWrite`  out  1  memory write enable; memory writes on the `clk` edge.
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  combinational read data from memory.

## Operation
- FSM states: IDLE, RD, WR, RESP. `req_ready` = (state==IDLE) & ~`rst`.
- On accept, latch `req_we`, `req_funct3`, `req_addr` and `req_wdata`, then branch as follows.
- Error (misaligned, illegal funct3 or out of range): go to RESP with `rsp_error`=1.
- Load: go to RD.
- SW: go to WR.
- SB/SH: go to RD, then WR.
- Error conditions:
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Illegal funct3 for loads: 011, 110, 111.
  - Illegal funct3 for stores: anything other than 000/001/010.
- RD: `MemRead`=1 and `mem_addr` valid. At the closing edge, capture `mem_rdata` into the internal word register. Next state is RESP for loads, WR for SB/SH.
- WR: `MemWrite`=1, `mem_wdata` = merged word. Next state is RESP.
  - SW: `mem_wdata` = `req_wdata`.
  - SB: captured word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: captured word with halfword lane addr[1] replaced by wdata[15:0].
- Byte order is little-endian: lane 0 = bits [7:0].
- Load result:
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: whole word.
- RESP: `rsp_valid`=1 for exactly one cycle, with `rsp_rdata`/`rsp_error`. Next state is IDLE. There is no response backpressure.
- `MemRead` and `MemWrite` are never high in the same cycle, and are 0 in IDLE and RESP. `mem_addr`/`mem_wdata` hold their last value outside RD/WR.
- `req_valid` is ignored outside IDLE.

## Timing
- Count from the accept edge, cycle 0:
  - Load: RD in cycle 1, `rsp_valid` in cycle 2.
  - SW: WR in cycle 1, `rsp_valid` in cycle 2.
  - SB/SH: RD in cycle 1, WR in cycle 2, `rsp_valid` in cycle 3.
  - Error: `rsp_valid` in cycle 1, with no memory cycle at all.
- The next request can be accepted at the edge that ends the RESP cycle +1; IDLE must be re-entered first.
- Reset values: state IDLE; `rsp_valid`, `rsp_error`, `MemRead`, `MemWrite` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata` = 0; `req_ready` = 0 while `rst` is high.
- Reset mid-operation aborts immediately.
  - `MemWrite` must drop asynchronously.
  - An RMW interrupted in RD leaves memory unchanged.
  - No response is issued for the aborted request.
- Address bits [1:0] never reach `mem_addr`.

## Test plan
- Preload word 0x40 = 0x8899AABB. LB 0x41 → `rsp_rdata` 0xFFFFFFAA in cycle 2; `MemRead` high for exactly one cycle; `MemWrite` never high.
- Same word: LH 0x42 → 0xFFFF8899; LHU 0x42 → 0x00008899; LBU 0x40 → 0x000000BB; LW 0x40 → 0x8899AABB.
- SB 0x43 with wdata 0x123456CD → RD cycle, then WR cycle with `mem_wdata` 0xCD99AABB, `rsp_valid` in cycle 3. A following LW 0x40 returns 0xCD99AABB. Then SH 0x40 with wdata 0x00001234 → 0xCD991234.
- SW 0x46, LH 0x41, and load with funct3 011 → each gives `rsp_error`=1 in cycle 1, `rsp_rdata`=0, no `MemRead`/`MemWrite`. With `ADDR_BITS`=10, LW 0x400 → error.
- `req_valid` held high with back-to-back LW 0x40 / SW 0x44 → each accepted only in IDLE, exactly one `rsp_valid` per request, in order.
- Assert `rst` during the RD cycle of SH 0x44 → `MemWrite` never asserts, word 0x44 unchanged, no `rsp_valid`. After release, `req_ready`=1 and outputs are at reset values.
